fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline: owns the PC, drives imem address, registers IF/ID.
//  Feeds InstrD/PCD/PCPlus4D to the decode controller; honours hazard-unit StallF/StallD/FlushD.
//  Applies EX-stage redirects (branch/jal/jalr).
//  Halts fetch cleanly when decode flags an unknown opcode (DoneD), with a drain FSM.
// PARAMETERS
//  XLEN          32            datapath/PC width
//  RESET_PC      32'h0000_0000 PC value after reset
//  NOP_INSTR     32'h0000_0013 bubble (addi x0,x0,0)
//  DRAIN_CYCLES  3             cycles waited in DRAIN before HALT (ID->WB depth)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     reset; one clock; reset is asynchronous and active-low
//  PCF        out  XLEN  imem address (combinational read)
//  InstrF     in   32    imem read data for PCF
//  PCSrcE     in   1     redirect taken in EX
//  PCTargetE  in   XLEN  redirect target
//  StallF     in   1     hold PC
//  StallD     in   1     hold IF/ID
//  FlushD     in   1     bubble IF/ID
//  DoneD      in   1     decode saw unsupported opcode
//  InstrD     out  32    IF/ID instruction
//  PCD        out  XLEN  IF/ID PC
//  PCPlus4D   out  XLEN  IF/ID PC+4
//  ValidD     out  1     IF/ID holds a real instruction
//  halted     out  1     fetch stopped, pipeline drained
// BEHAVIOUR
//  Reset (async, rst_n=0): PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0,
//   halted=0, state=RUN, drain count=0. First fetch at first edge after deassert.
//  PC next (priority): PCSrcE -> PCTargetE; else StallF or state!=RUN -> hold; else PCF+4.
//   PCSrcE overrides StallF. Add wraps mod 2^XLEN; no alignment check.
//  IF/ID (priority): FlushD or PCSrcE -> bubble (NOP_INSTR, ValidD=0, PC fields kept);
//   else StallD -> hold; else state!=RUN -> bubble; else load InstrF, PCF, PCF+4, ValidD=1.
//  Latency: InstrF at PCF appears on InstrD one cycle later.
//  FSM states RUN, DRAIN, HALT:
//   RUN  : DoneD & ValidD & !FlushD & !PCSrcE -> DRAIN, count=0. Bubbles never trigger.
//   DRAIN: fetch frozen, IF/ID bubbles; count++ per cycle.
//          PCSrcE -> RUN (older branch squashed the bad instr); PC=PCTargetE.
//          count==DRAIN_CYCLES-1 & !PCSrcE -> HALT.
//   HALT : halted=1 (registered), PC frozen, IF/ID bubble; exits only via reset.
//  Simultaneous DoneD+PCSrcE in RUN: redirect wins, stay RUN.
//  DoneD while StallD: transition only once stall releases (instruction not yet accepted).
//  Reset mid-DRAIN/HALT: immediate return to reset values above.
// STRUCTURE
//  Shared package (cpu_pkg): fetch state enum {RUN,DRAIN,HALT}, NOP_INSTR, opcode constants
//   shared with decode controller.
//  One sub-module: if_id_reg (flush/stall/load register for InstrD/PCD/PCPlus4D/ValidD).
//  PC register, adder, next-PC mux and FSM live in fetch_stage.
// TESTING
//  1 Reset release, imem returns 0x00500093 @0 -> PCF 0,4,8..; cycle 2 InstrD=0x00500093, PCD=0, PCPlus4D=4, ValidD=1.
//  2 StallF=StallD=1 for 2 cycles at PCF=8 -> PCF stays 8, InstrD/PCD unchanged; resumes at 12.
//  3 PCSrcE=1, PCTargetE=0x40 with StallF=1 -> next PCF=0x40, InstrD=NOP, ValidD=0.
//  4 InstrD=0xFFFFFFFF (DoneD=1, ValidD=1) -> DRAIN; PCF frozen; halted=1 after 3 cycles; stays.
//  5 DRAIN entered, PCSrcE=1 target 0x80 on 2nd DRAIN cycle -> RUN, PCF=0x80, halted never set.
//  6 rst_n low asynchronously while HALT -> PCF=0, halted=0, ValidD=0 without waiting for clk.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and constants shared between the fetch stage and the decode controller.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  // RV32I base opcodes; anything else makes decode raise DoneD
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats bubble, bubble beats load.
module if_id_reg #(
  parameter int          XLEN = 32,
  parameter logic [31:0] NOP  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            bubble,
  input  logic [31:0]     instr_f,
  input  logic [XLEN-1:0] pc_f,
  input  logic [XLEN-1:0] pc_plus4_f,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  // Bubbles only replace the instruction; PC fields keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end else if (stall) begin
      instr_d <= instr_d;
    end else if (bubble) begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end else begin
      instr_d    <= instr_f;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, IF/ID register and the halt/drain controller.
//  state | meaning
//  RUN   | fetching normally
//  DRAIN | bad opcode accepted; fetch frozen while older instructions retire
//  HALT  | pipeline drained, halted asserted until reset
module fetch_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter logic [31:0]     NOP_INSTR    = cpu_pkg::NOP_INSTR,
  parameter int              DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] PCF,
  input  logic [31:0]     InstrF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            DoneD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            halted
);
  import cpu_pkg::*;

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DRAIN_CYCLES - 1);

  fetch_state_e  state, state_nxt;
  logic [CW-1:0] drain_cnt, drain_cnt_nxt;
  logic [XLEN-1:0] pc_plus4, pc_nxt;
  logic run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // A stalled decode has not accepted the instruction yet, so DoneD waits.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    unique case (state)
      RUN: begin
        if (DoneD && ValidD && !FlushD && !PCSrcE && !StallD) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      DRAIN: begin
        if (PCSrcE) begin
          state_nxt     = RUN;
          drain_cnt_nxt = '0;
        end else if (drain_cnt == LAST_CNT) begin
          state_nxt = HALT;
        end else begin
          drain_cnt_nxt = drain_cnt + 1'b1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    run    = (state == RUN);
    halted = (state == HALT);
  end

  assign pc_plus4 = PCF + XLEN'(4);

  always_comb begin
    if (PCSrcE)             pc_nxt = PCTargetE;
    else if (StallF || !run) pc_nxt = PCF;
    else                    pc_nxt = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) PCF <= RESET_PC;
    else        PCF <= pc_nxt;
  end

  if_id_reg #(.XLEN(XLEN), .NOP(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (FlushD || PCSrcE),
    .stall      (StallD),
    .bubble     (!run),
    .instr_f    (InstrF),
    .pc_f       (PCF),
    .pc_plus4_f (pc_plus4),
    .instr_d    (InstrD),
    .pc_d       (PCD),
    .pc_plus4_d (PCPlus4D),
    .valid_d    (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences, random vs. model.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF, InstrF, PCTargetE, InstrD, PCD, PCPlus4D;
  logic        PCSrcE, StallF, StallD, FlushD, DoneD, ValidD, halted;
  logic [31:0] bad_addr;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
  bit          m_valid, m_halted, m_draining;
  int          m_left;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .InstrF(InstrF), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .DoneD(DoneD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a, input logic [31:0] bad);
    if (a == bad) return 32'hFFFF_FFFF;
    if (a == 32'h0) return 32'h0050_0093;
    return {a[11:0], 20'h00093};
  endfunction

  assign InstrF = imem(PCF, bad_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4d = 32'h0;
    m_valid = 0; m_halted = 0; m_draining = 0; m_left = 0;
  endtask

  task automatic model_edge(input bit sf, input bit sd, input bit fd, input bit ps,
                            input logic [31:0] tgt, input bit dn);
    logic [31:0] fetched;
    bit running, take;
    fetched = imem(m_pc, bad_addr);
    running = !m_draining && !m_halted;
    take    = running && dn && m_valid && !fd && !ps && !sd;
    if (fd || ps) begin
      m_instr = NOP; m_valid = 0;
    end else if (sd) begin
      m_instr = m_instr;
    end else if (!running) begin
      m_instr = NOP; m_valid = 0;
    end else begin
      m_instr = fetched; m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1;
    end
    if (ps) m_pc = tgt;
    else if (!sf && running) m_pc = m_pc + 32'd4;
    if (take) begin
      m_draining = 1; m_left = DRAIN;
    end else if (m_draining) begin
      if (ps) m_draining = 0;
      else begin
        m_left--;
        if (m_left == 0) begin m_draining = 0; m_halted = 1; end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".PCF"}, PCF, m_pc);
    chk({tag, ".InstrD"}, InstrD, m_instr);
    chk({tag, ".PCD"}, PCD, m_pcd);
    chk({tag, ".PCPlus4D"}, PCPlus4D, m_pc4d);
    chk({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, m_valid});
    chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
  endtask

  task automatic step(input bit sf, input bit sd, input bit fd, input bit ps,
                      input logic [31:0] tgt, input bit dn, input string tag);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt; DoneD = dn;
    model_edge(sf, sd, fd, ps, tgt, dn);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  // Called 1 ns after a rising edge: assert reset mid-cycle, check without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_PCF"}, PCF, 32'h0);
    chk({tag, ".rst_halted"}, {31'b0, halted}, 32'h0);
    chk({tag, ".rst_ValidD"}, {31'b0, ValidD}, 32'h0);
    chk({tag, ".rst_InstrD"}, InstrD, NOP);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit sf, sd, fd, ps;
    logic [31:0] tgt;
    bit dn;
    logic [31:0] pcf, instr, pcd, pc4;
    bit valid;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0,0,0,0,32'h0,0,  32'h04, 32'h0050_0093, 32'h00, 32'h04, 1};
    tbl[1]  = '{0,0,0,0,32'h0,0,  32'h08, 32'h0040_0093, 32'h04, 32'h08, 1};
    tbl[2]  = '{1,1,0,0,32'h0,0,  32'h08, 32'h0040_0093, 32'h04, 32'h08, 1};
    tbl[3]  = '{1,1,0,0,32'h0,0,  32'h08, 32'h0040_0093, 32'h04, 32'h08, 1};
    tbl[4]  = '{0,0,0,0,32'h0,0,  32'h0C, 32'h0080_0093, 32'h08, 32'h0C, 1};
    tbl[5]  = '{1,0,0,1,32'h40,0, 32'h40, NOP,           32'h08, 32'h0C, 0};
    tbl[6]  = '{0,0,0,0,32'h0,0,  32'h44, 32'h0400_0093, 32'h40, 32'h44, 1};
    tbl[7]  = '{0,0,1,0,32'h0,0,  32'h48, NOP,           32'h40, 32'h44, 0};
    tbl[8]  = '{0,0,0,0,32'h0,0,  32'h4C, 32'h0480_0093, 32'h48, 32'h4C, 1};
    tbl[9]  = '{0,0,0,1,32'h10,1, 32'h10, NOP,           32'h48, 32'h4C, 0};
    tbl[10] = '{0,0,0,0,32'h0,0,  32'h14, 32'h0100_0093, 32'h10, 32'h14, 1};
    tbl[11] = '{1,1,0,0,32'h0,1,  32'h14, 32'h0100_0093, 32'h10, 32'h14, 1};
    tbl[12] = '{0,0,0,0,32'h0,0,  32'h18, 32'h0140_0093, 32'h14, 32'h18, 1};

    rst_n = 1'b0; bad_addr = 32'h2;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 32'h0; DoneD = 0;
    model_reset();
    #12;
    chk("reset.PCF", PCF, 32'h0);
    chk("reset.InstrD", InstrD, NOP);
    chk("reset.PCD", PCD, 32'h0);
    chk("reset.PCPlus4D", PCPlus4D, 32'h0);
    chk("reset.ValidD", {31'b0, ValidD}, 32'h0);
    chk("reset.halted", {31'b0, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].sf, tbl[i].sd, tbl[i].fd, tbl[i].ps, tbl[i].tgt, tbl[i].dn, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tPCF", i), PCF, tbl[i].pcf);
      chk($sformatf("vec%0d.tInstrD", i), InstrD, tbl[i].instr);
      chk($sformatf("vec%0d.tPCD", i), PCD, tbl[i].pcd);
      chk($sformatf("vec%0d.tPCPlus4D", i), PCPlus4D, tbl[i].pc4);
      chk($sformatf("vec%0d.tValidD", i), {31'b0, ValidD}, {31'b0, tbl[i].valid});
      chk($sformatf("vec%0d.thalted", i), {31'b0, halted}, 32'h0);
    end

    // bad opcode fetched at 0x18 -> drain -> halt, PC frozen
    bad_addr = 32'h18;
    step(0,0,0,0,32'h0,0, "bad_fetch");
    chk("bad_fetch.InstrD", InstrD, 32'hFFFF_FFFF);
    step(0,0,0,0,32'h0,1, "drain_enter");
    chk("drain_enter.PCF", PCF, 32'h20);
    step(0,0,0,0,32'h0,0, "drain1");
    chk("drain1.PCF", PCF, 32'h20);
    chk("drain1.ValidD", {31'b0, ValidD}, 32'h0);
    step(0,0,0,0,32'h0,0, "drain2");
    chk("drain2.halted", {31'b0, halted}, 32'h0);
    step(0,0,0,0,32'h0,0, "drain3");
    chk("drain3.halted", {31'b0, halted}, 32'h1);
    step(0,0,0,0,32'h0,0, "halt1");
    step(0,0,0,0,32'h0,1, "halt2");
    chk("halt2.PCF", PCF, 32'h20);
    chk("halt2.halted", {31'b0, halted}, 32'h1);
    bad_addr = 32'h2;

    async_reset("halt_reset");

    // redirect during DRAIN returns to RUN
    step(0,0,0,0,32'h0,0, "r5a");
    step(0,0,0,0,32'h0,0, "r5b");
    step(0,0,0,0,32'h0,1, "r5_enter");
    step(0,0,0,0,32'h0,0, "r5_drain1");
    chk("r5_drain1.PCF", PCF, 32'h0C);
    step(0,0,0,1,32'h80,0, "r5_redirect");
    chk("r5_redirect.PCF", PCF, 32'h80);
    step(0,0,0,0,32'h0,0, "r5_run1");
    chk("r5_run1.PCF", PCF, 32'h84);
    chk("r5_run1.ValidD", {31'b0, ValidD}, 32'h1);
    for (int i = 0; i < 4; i++) step(0,0,0,0,32'h0,0, "r5_run");
    chk("r5_never_halted", {31'b0, halted}, 32'h0);

    // wrap of the PC adder
    step(0,0,0,1,32'hFFFF_FFFC,0, "wrap_a");
    step(0,0,0,0,32'h0,0, "wrap_b");
    chk("wrap.PCF", PCF, 32'h0);
    chk("wrap.PCPlus4D", PCPlus4D, 32'h0);

    for (int i = 0; i < 400; i++) begin
      bit sf, sd, fd, ps, dn;
      logic [31:0] tgt;
      if ((m_halted && ($urandom % 4 == 0)) || ($urandom % 150 == 0)) begin
        async_reset("rnd");
      end
      sf  = ($urandom % 4) == 0;
      sd  = ($urandom % 4) == 0;
      fd  = ($urandom % 8) == 0;
      ps  = ($urandom % 8) == 0;
      dn  = ($urandom % 6) == 0;
      tgt = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
      step(sf, sd, fd, ps, tgt, dn, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
